// File: rtl/midi_voice_allocator.sv
// MIDI channel-voice parser with running status, feeding a voice allocator.
// Allocation order is retrigger, then free voice, then steal the oldest voice.
module midi_voice_allocator #(
  parameter int         pVoiceNum = 4,
  parameter logic [3:0] pMidiCh   = 4'h0
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [7:0]               iMidiRd,
  input  logic                     iMidiVd,
  output logic [pVoiceNum-1:0]     oVoiceGate,
  output logic [7*pVoiceNum-1:0]   oVoiceNote,
  output logic [7*pVoiceNum-1:0]   oVoiceVel,
  output logic [pVoiceNum-1:0]     oVoiceTrig,
  output logic                     oVoiceStolen,
  output logic [1:0]               oParserState
);

  localparam int IW = $clog2(pVoiceNum);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_D1 = 2'd1, S_D2 = 2'd2} state_t;

  state_t         state, stateNxt;
  logic [7:0]     runStatus, runStatusNxt;
  logic [6:0]     d1, d1Nxt;
  logic           msgDone;
  logic [6:0]     msgD1, msgD2;

  logic [pVoiceNum-1:0] gate, gateNxt;
  logic [pVoiceNum-1:0] trig, trigNxt;
  logic                 stolen, stolenNxt;
  logic [6:0]           note    [pVoiceNum];
  logic [6:0]           noteNxt [pVoiceNum];
  logic [6:0]           vel     [pVoiceNum];
  logic [6:0]           velNxt  [pVoiceNum];
  logic [IW-1:0]        rank    [pVoiceNum];
  logic [IW-1:0]        rankNxt [pVoiceNum];

  // Parser. Handshake: a byte is consumed in exactly the cycles where
  // iMidiVd is high; there is no backpressure, so msgDone is a one-cycle
  // strobe in the cycle carrying the final byte of a message.
  always_comb begin
    stateNxt     = state;
    runStatusNxt = runStatus;
    d1Nxt        = d1;
    msgDone      = 1'b0;
    if (iMidiVd) begin
      if (iMidiRd >= 8'hF8) begin
        stateNxt = state;
      end else if (iMidiRd >= 8'hF0) begin
        runStatusNxt = 8'h00;
        stateNxt     = S_IDLE;
      end else if (iMidiRd[7]) begin
        runStatusNxt = iMidiRd;
        stateNxt     = S_D1;
      end else begin
        case (state)
          S_IDLE, S_D1: begin
            if (state == S_D1 || runStatus[7]) begin
              d1Nxt = iMidiRd[6:0];
              // Program change and channel pressure carry a single data byte.
              if (runStatus[7:5] == 3'b110) begin
                msgDone  = 1'b1;
                stateNxt = S_D1;
              end else begin
                stateNxt = S_D2;
              end
            end
          end
          S_D2: begin
            msgDone  = 1'b1;
            stateNxt = S_D1;
          end
          default: stateNxt = S_IDLE;
        endcase
      end
    end
  end

  assign msgD1 = (state == S_D2) ? d1 : iMidiRd[6:0];
  assign msgD2 = iMidiRd[6:0];

  logic chOk, noteOn, noteOff, allOff;
  assign chOk    = msgDone && (runStatus[3:0] == pMidiCh);
  assign noteOn  = chOk && (runStatus[7:4] == 4'h9) && (msgD2 != 7'd0);
  assign noteOff = chOk && ((runStatus[7:4] == 4'h8) ||
                            ((runStatus[7:4] == 4'h9) && (msgD2 == 7'd0)));
  assign allOff  = chOk && (runStatus[7:4] == 4'hB) && (msgD1 == 7'h7B);

  logic          hit, free;
  logic [IW-1:0] hitIdx, freeIdx, oldIdx, allocIdx;

  // Lowest index wins for both the key match and the free-voice search.
  always_comb begin
    hit     = 1'b0;
    free    = 1'b0;
    hitIdx  = '0;
    freeIdx = '0;
    oldIdx  = '0;
    for (int v = pVoiceNum - 1; v >= 0; v--) begin
      if (gate[v] && (note[v] == msgD1)) begin
        hit    = 1'b1;
        hitIdx = IW'(v);
      end
      if (!gate[v]) begin
        free    = 1'b1;
        freeIdx = IW'(v);
      end
      if (rank[v] == IW'(pVoiceNum - 1)) oldIdx = IW'(v);
    end
    if (hit)       allocIdx = hitIdx;
    else if (free) allocIdx = freeIdx;
    else           allocIdx = oldIdx;
  end

  always_comb begin
    gateNxt   = gate;
    trigNxt   = '0;
    stolenNxt = 1'b0;
    for (int v = 0; v < pVoiceNum; v++) begin
      noteNxt[v] = note[v];
      velNxt[v]  = vel[v];
      rankNxt[v] = rank[v];
    end
    if (noteOn) begin
      noteNxt[allocIdx] = msgD1;
      velNxt[allocIdx]  = msgD2;
      gateNxt[allocIdx] = 1'b1;
      trigNxt[allocIdx] = 1'b1;
      stolenNxt         = !hit && !free;
      // Voices younger than the allocated one age by one; it becomes newest.
      for (int v = 0; v < pVoiceNum; v++) begin
        if (rank[v] < rank[allocIdx]) rankNxt[v] = rank[v] + IW'(1);
      end
      rankNxt[allocIdx] = '0;
    end else if (noteOff) begin
      if (hit) gateNxt[hitIdx] = 1'b0;
    end else if (allOff) begin
      gateNxt = '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= S_IDLE;
      runStatus <= 8'h00;
      d1        <= 7'd0;
      gate      <= '0;
      trig      <= '0;
      stolen    <= 1'b0;
      for (int v = 0; v < pVoiceNum; v++) begin
        note[v] <= 7'd0;
        vel[v]  <= 7'd0;
        rank[v] <= IW'(v);
      end
    end else begin
      state     <= stateNxt;
      runStatus <= runStatusNxt;
      d1        <= d1Nxt;
      gate      <= gateNxt;
      trig      <= trigNxt;
      stolen    <= stolenNxt;
      for (int v = 0; v < pVoiceNum; v++) begin
        note[v] <= noteNxt[v];
        vel[v]  <= velNxt[v];
        rank[v] <= rankNxt[v];
      end
    end
  end

  for (genvar v = 0; v < pVoiceNum; v++) begin : gPack
    assign oVoiceNote[7*v +: 7] = note[v];
    assign oVoiceVel[7*v +: 7]  = vel[v];
  end

  assign oVoiceGate   = gate;
  assign oVoiceTrig   = trig;
  assign oVoiceStolen = stolen;
  assign oParserState = state;

endmodule
